msrv32_ifetch: RTL and testbench

Instruction fetch stage of the MSRV32 core. Owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, buffers returned words with their PCs in a small FIFO, and presents them to the instruction mux with a valid/ready handshake. Drives the mux's `flush_in` so the mux emits NOP (`32'h0000_0013`) whenever no valid instruction is available or a redirect is in progress. Discards stale in-flight responses after a branch or trap redirect.

---
 rtl/msrv32_pkg.sv | 13 +
 rtl/msrv32_ifetch_if.sv | 29 ++
 rtl/msrv32_ifetch_fifo.sv | 70 +++++++
 rtl/msrv32_ifetch.sv | 95 +++++++++
 tb/tb_msrv32_ifetch.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/msrv32_pkg.sv
// Shared MSRV32 constants and the fetch-buffer entry type.
package msrv32_pkg;
    localparam int          MSRV32_XLEN     = 32;
    localparam logic [31:0] MSRV32_NOP      = 32'h0000_0013;
    localparam logic [31:0] MSRV32_RESET_PC = 32'h0000_0000;

    typedef logic [MSRV32_XLEN-1:0] msrv32_word_t;

    typedef struct packed {
        msrv32_word_t pc;
        msrv32_word_t instr;
    } msrv32_fetch_ent_t;
endpackage

// File: rtl/msrv32_ifetch_if.sv
// Instruction-memory request/response bus plus the fetch-to-mux instruction handshake.
interface msrv32_ifetch_if;
    import msrv32_pkg::*;

    logic         imem_req_out;
    msrv32_word_t imem_addr_out;
    logic         imem_gnt_in;
    logic         imem_rvalid_in;
    msrv32_word_t imem_rdata_in;
    logic         instr_valid_out;
    logic         instr_ready_in;
    msrv32_word_t instr_out;
    msrv32_word_t pc_out;
    logic         flush_out;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_gnt_in, imem_rvalid_in, imem_rdata_in,
        output instr_valid_out, instr_out, pc_out, flush_out,
        input  instr_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_gnt_in, imem_rvalid_in, imem_rdata_in,
        input  instr_valid_out, instr_out, pc_out, flush_out,
        output instr_ready_in
    );
endinterface

// File: rtl/msrv32_ifetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; clear wins over push and pop.
module msrv32_ifetch_fifo
    import msrv32_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic             clear_in,
    input  logic [WIDTH-1:0] wdata_in,
    output logic [WIDTH-1:0] rdata_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [CNT_W-1:0] count_out
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Pointer and occupancy update; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        do_pop_s  = pop_in && (count_q != {CNT_W{1'b0}});
        do_push_s = push_in && ((count_q != FULL_CNT) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear_in) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            else           rd_ptr_d = rd_ptr_q;
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (do_push_s && !clear_in) mem_q[wr_ptr_q] <= wdata_in;
    end

    assign rdata_out = mem_q[rd_ptr_q];
    assign full_out  = (count_q == FULL_CNT);
    assign empty_out = (count_q == {CNT_W{1'b0}});
    assign count_out = count_q;
endmodule

// File: rtl/msrv32_ifetch.sv
// MSRV32 fetch stage: PC, credit-limited memory requests, stale-response dropping, output FIFO.
module msrv32_ifetch
    import msrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MSRV32_RESET_PC,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   redirect_in,
    input  logic [31:0]            redirect_pc_in,
    msrv32_ifetch_if.master        bus
);
    localparam int               CNT_W        = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s, fifo_empty_s;
    msrv32_fetch_ent_t fifo_wdata_s, fifo_head_s;
    logic              req_s, fire_s, push_s, pop_s, head_valid_s;
    logic [31:0]       resp_pc_s;

    // Credit check, handshakes, and PC of the oldest in-flight request.
    always_comb begin
        head_valid_s = !fifo_empty_s;
        req_s        = !rst_in && !redirect_in &&
                       (({1'b0, outstanding_q} + {1'b0, fifo_count_s}) < CREDIT_LIMIT);
        fire_s       = req_s && bus.imem_gnt_in;
        // Requests are granted at consecutive word addresses, so the oldest one sits
        // 'outstanding' words behind the next fetch address.
        resp_pc_s    = fetch_pc_q - {{(30 - CNT_W){1'b0}}, outstanding_q, 2'b00};
        pop_s        = head_valid_s && bus.instr_ready_in && !redirect_in;
        push_s       = bus.imem_rvalid_in && !redirect_in &&
                       (drop_cnt_q == {CNT_W{1'b0}}) && (!fifo_full_s || pop_s);
        fifo_wdata_s.pc    = resp_pc_s;
        fifo_wdata_s.instr = bus.imem_rdata_in;
    end

    // Next fetch PC, in-flight count and drop count; a redirect overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(fire_s) - CNT_W'(bus.imem_rvalid_in);
        if (redirect_in) begin
            fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
            drop_cnt_d = outstanding_q - CNT_W'(bus.imem_rvalid_in);
        end else begin
            if (fire_s) fetch_pc_d = fetch_pc_q + 32'd4;
            else        fetch_pc_d = fetch_pc_q;
            if (bus.imem_rvalid_in && (drop_cnt_q != {CNT_W{1'b0}}))
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            else
                drop_cnt_d = drop_cnt_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CNT_W{1'b0}};
            drop_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    msrv32_ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(msrv32_fetch_ent_t))
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (push_s),
        .pop_in    (pop_s),
        .clear_in  (redirect_in),
        .wdata_in  (fifo_wdata_s),
        .rdata_out (fifo_head_s),
        .full_out  (fifo_full_s),
        .empty_out (fifo_empty_s),
        .count_out (fifo_count_s)
    );

    assign bus.imem_req_out    = req_s;
    assign bus.imem_addr_out   = fetch_pc_q;
    assign bus.instr_valid_out = head_valid_s;
    assign bus.instr_out       = head_valid_s ? fifo_head_s.instr : 32'h0000_0000;
    assign bus.pc_out          = head_valid_s ? fifo_head_s.pc    : 32'h0000_0000;
    assign bus.flush_out       = redirect_in || !head_valid_s;
endmodule

// File: tb/tb_msrv32_ifetch.sv
// Randomised bench for msrv32_ifetch: memory responder plus a queue-based reference of the fetch stage.
module tb_msrv32_ifetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    logic        clk = 1'b0;
    logic        rst, redirect, gnt, ready;
    logic [31:0] redirect_pc;
    int          lat, cyc;
    int          checks, errors;

    mreq_t       memq[$];
    infl_t       m_infl[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc;

    logic        o_req, o_valid, o_flush, e_req, e_valid, e_flush;
    logic [31:0] o_addr, o_instr, o_pc, e_addr, e_instr, e_pc;
    logic [98:0] obs_v, exp_v;

    msrv32_ifetch_if bus();

    msrv32_ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .redirect_in    (redirect),
        .redirect_pc_in (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    // One clock: drive memory/inputs, predict and sample outputs, then advance memory and model.
    task automatic tick();
        mreq_t m;
        infl_t f;
        ent_t  e;
        bit    rv, do_push;
        rv = (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imem_rvalid_in = rv;
        if (rv) bus.imem_rdata_in = mem_word(memq[0].addr);
        else    bus.imem_rdata_in = $urandom;
        bus.imem_gnt_in    = gnt;
        bus.instr_ready_in = ready;
        #1;
        e_req   = !rst && !redirect && ((m_infl.size() + m_fifo.size()) < DEPTH);
        e_addr  = m_pc;
        e_valid = (m_fifo.size() != 0);
        e_instr = e_valid ? m_fifo[0].instr : 32'h0;
        e_pc    = e_valid ? m_fifo[0].pc : 32'h0;
        e_flush = redirect || !e_valid;
        o_req   = bus.imem_req_out;   o_addr  = bus.imem_addr_out;
        o_valid = bus.instr_valid_out; o_instr = bus.instr_out;
        o_pc    = bus.pc_out;          o_flush = bus.flush_out;
        obs_v = {o_req, o_addr, o_valid, o_instr, o_pc, o_flush};
        exp_v = {e_req, e_addr, e_valid, e_instr, e_pc, e_flush};
        @(posedge clk);
        if (rv) m = memq.pop_front();
        if (o_req && gnt) begin m.addr = o_addr; m.due = cyc + lat; memq.push_back(m); end
        if (rst) memq.delete();
        if (rst) begin
            m_pc = RESET_PC; m_infl.delete(); m_fifo.delete();
        end else begin
            do_push = 1'b0;
            if (rv && m_infl.size() > 0) begin
                f = m_infl.pop_front();
                if (!redirect && !f.stale) begin
                    e.pc = f.pc; e.instr = mem_word(f.pc); do_push = 1'b1;
                end
            end
            if (e_valid && ready && !redirect) e = (do_push) ? e : e;
            if (e_valid && ready && !redirect) void'(m_fifo.pop_front());
            if (do_push) m_fifo.push_back(e);
            if (e_req && gnt) begin
                f.pc = m_pc; f.stale = 1'b0; m_infl.push_back(f); m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                m_fifo.delete();
                foreach (m_infl[k]) m_infl[k].stale = 1'b1;
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; gnt = 1'b1; ready = 1'b1; lat = 1;
        tick();
        repeat (2) begin
            tick();
            checks++;
            if (obs_v !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b1}) begin
                errors++; $display("FAIL reset_values got=%h exp=%h", obs_v, {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b1});
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            errors++; $display("FAIL first_request got req=%b addr=%h exp req=1 addr=%h", o_req, o_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int nvalid = 0;
        logic [31:0] next_pc = RESET_PC;
        gnt = 1'b1; ready = 1'b1; lat = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
            if (o_valid === 1'b1) begin
                checks++;
                if (o_pc !== next_pc) begin errors++; $display("FAIL stream_pc got=%h exp=%h", o_pc, next_pc); end
                next_pc = next_pc + 32'd4;
            end
            if (i >= 2 && o_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 10) begin errors++; $display("FAIL stream_throughput got=%0d exp=10", nvalid); end
    endtask

    task automatic test_backpressure();
        int nvalid = 0;
        logic [31:0] first_pc;
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
        end
        checks++;
        if (o_req !== 1'b0 || o_valid !== 1'b1) begin
            errors++; $display("FAIL credit_stop got req=%b valid=%b exp req=0 valid=1", o_req, o_valid);
        end
        ready = 1'b1;
        first_pc = o_pc;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL release cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
            if (o_valid === 1'b1 && o_pc === first_pc + 32'(4 * i)) nvalid++;
        end
        checks++;
        if (nvalid != 4) begin errors++; $display("FAIL release_order got=%0d exp=4", nvalid); end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        gnt = 1'b0; ready = 1'b1; lat = 3;
        repeat (6) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL redirect_drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
        end
        gnt = 1'b1;
        repeat (2) tick();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        checks++;
        if (o_req !== 1'b0 || o_flush !== 1'b1) begin
            errors++; $display("FAIL redirect_cycle got req=%b flush=%b exp req=0 flush=1", o_req, o_flush);
        end
        redirect = 1'b0; gnt = 1'b1;
        tick();
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL redirect_target got req=%b addr=%h exp req=1 addr=00000100", o_req, o_addr);
        end
        for (int i = 0; i < 12 && !found; i++) begin
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL redirect_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
            if (o_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (o_pc !== 32'h0000_0100) begin errors++; $display("FAIL redirect_first_pc got=%h exp=00000100", o_pc); end
            end else begin
                checks++;
                if (o_flush !== 1'b1) begin errors++; $display("FAIL redirect_flush got=%b exp=1", o_flush); end
                tick();
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL redirect_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_wrap();
        gnt = 1'b0; lat = 1;
        repeat (6) tick();
        gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_start got req=%b addr=%h exp req=1 addr=fffffffc", o_req, o_addr);
        end
        tick();
        checks++;
        if (o_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", o_addr); end
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL wrap_model got=%h exp=%h", obs_v, exp_v); end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] held;
        gnt = 1'b0; ready = 1'b1; lat = 1;
        tick();
        held = o_addr;
        repeat (5) begin
            tick();
            checks++;
            if (o_addr !== held || o_req !== 1'b1 || obs_v !== exp_v) begin
                errors++; $display("FAIL gnt_stall got addr=%h req=%b exp addr=%h req=1", o_addr, o_req, held);
            end
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_addr !== 32'h0000_0040) begin
            errors++; $display("FAIL redirect_rvalid_drop got valid=%b addr=%h exp valid=0 addr=00000040", o_valid, o_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            gnt         = ($urandom_range(0, 3) != 0);
            ready       = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            rst         = (i == 300 || i == 301);
            tick();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
        end
        rst = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_pc = RESET_PC;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_gnt_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
